// File: rtl/demux_buffered.sv
// rtl/demux_buffered.sv - 1-to-2 stream demux with a 2-entry FIFO and a transfer counter per port
module demux_buffered_fifo2 #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [width-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_full,
    output logic [width-1:0] o_data
);
    logic [width-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;
    logic [width-1:0] r_head;

    logic             w_pop;
    logic             w_rptr_n;
    logic [1:0]       w_occ_n;
    logic [width-1:0] w_head_n;

    assign o_valid = (r_occ != 2'd0);
    assign o_full  = (r_occ == 2'd2);
    assign o_data  = r_head;
    assign w_pop   = o_valid && i_ready;

    // The head is a register of its own so it keeps its last value when the FIFO drains.
    always_comb begin
        w_rptr_n = r_rptr ^ w_pop;
        w_occ_n  = r_occ + {1'b0, i_push} - {1'b0, w_pop};
        w_head_n = r_head;
        if (w_occ_n != 2'd0) begin
            if (i_push && (r_wptr == w_rptr_n))
                w_head_n = i_data;
            else
                w_head_n = r_mem[w_rptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
            r_head   <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            r_rptr <= w_rptr_n;
            r_occ  <= w_occ_n;
            r_head <= w_head_n;
        end
    end
endmodule

module demux_buffered #(
    parameter int width     = 16,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sel,
    input  logic [width-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out0_valid,
    output logic [width-1:0]     out0_data,
    input  logic                 out0_ready,
    output logic                 out1_valid,
    output logic [width-1:0]     out1_data,
    input  logic                 out1_ready,
    output logic [cnt_width-1:0] cnt0,
    output logic [cnt_width-1:0] cnt1
);
    logic                 w_full0;
    logic                 w_full1;
    logic                 w_push0;
    logic                 w_push1;
    logic [cnt_width-1:0] r_cnt0;
    logic [cnt_width-1:0] r_cnt1;

    // Readiness looks only at the selected FIFO's occupancy, never at the consumer side.
    assign in_ready = in_sel ? ~w_full1 : ~w_full0;
    assign w_push0  = in_valid && in_ready && !in_sel;
    assign w_push1  = in_valid && in_ready &&  in_sel;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

    demux_buffered_fifo2 #(.width(width)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_full  (w_full0),
        .o_data  (out0_data)
    );

    demux_buffered_fifo2 #(.width(width)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_full  (w_full1),
        .o_data  (out1_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_push1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_buffered.sv
// tb/tb_demux_buffered.sv - scoreboard bench for demux_buffered
module tb_demux_buffered;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sel = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out0_valid, out1_valid;
    logic [15:0] out0_data, out1_data;
    logic        out0_ready = 1'b0;
    logic        out1_ready = 1'b0;
    logic [15:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    demux_buffered #(.width(16), .cnt_width(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every handshake seen on an output pops and compares the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out0_valid && out0_ready) begin
                n_cmp++;
                if (exp0.size() == 0) begin
                    n_err++;
                    $display("FAIL out0_unexpected: got %h expected none", out0_data);
                end else begin
                    logic [15:0] e;
                    e = exp0.pop_front();
                    if (out0_data !== e) begin
                        n_err++;
                        $display("FAIL out0_data: got %h expected %h", out0_data, e);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                n_cmp++;
                if (exp1.size() == 0) begin
                    n_err++;
                    $display("FAIL out1_unexpected: got %h expected none", out1_data);
                end else begin
                    logic [15:0] e;
                    e = exp1.pop_front();
                    if (out1_data !== e) begin
                        n_err++;
                        $display("FAIL out1_data: got %h expected %h", out1_data, e);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic sel, input logic [15:0] data);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            if (sel) exp1.push_back(data);
            else     exp0.push_back(data);
            @(posedge clk); #1;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got in_ready 0 expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        exp0.delete();
        exp1.delete();
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        @(posedge clk); #1;
        do_reset(2);
        @(negedge clk);
        check("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        check("rst_out0_data", {16'b0, out0_data}, 32'd0);
        check("rst_out1_data", {16'b0, out1_data}, 32'd0);
        check("rst_cnt0", {16'b0, cnt0}, 32'd0);
        check("rst_cnt1", {16'b0, cnt1}, 32'd0);
        check("rst_in_ready_sel0", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_sel = 1'b1;
        @(negedge clk);
        check("rst_in_ready_sel1", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single route
        out0_ready = 1'b1;
        push(1'b0, 16'hA5A5);
        @(negedge clk);
        check("single_valid", {31'b0, out0_valid}, 32'd1);
        check("single_data", {16'b0, out0_data}, 32'h0000A5A5);
        check("single_out1_idle", {31'b0, out1_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_popped", {31'b0, out0_valid}, 32'd0);
        check("single_cnt0", {16'b0, cnt0}, 32'd1);
        check("single_cnt1", {16'b0, cnt1}, 32'd0);
        @(posedge clk); #1;

        // Backpressure and isolation
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        push(1'b0, 16'h0001);
        push(1'b0, 16'h0002);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0003;
        @(negedge clk);
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push(1'b1, 16'h0004);
        @(negedge clk);
        check("bp_out0_hold_valid", {31'b0, out0_valid}, 32'd1);
        check("bp_out0_hold_data", {16'b0, out0_data}, 32'h00000001);
        check("bp_cnt0", {16'b0, cnt0}, 32'd3);
        check("bp_cnt1", {16'b0, cnt1}, 32'd1);
        @(posedge clk); #1;
        out0_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        check("bp_drained0", {31'b0, out0_valid}, 32'd0);
        check("bp_drained1", {31'b0, out1_valid}, 32'd0);
        @(posedge clk); #1;

        // Full FIFO with a concurrent pop still refuses the push
        out0_ready = 1'b0;
        push(1'b0, 16'h0001);
        push(1'b0, 16'h0002);
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0003;
        @(negedge clk);
        check("fullpop_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        push(1'b0, 16'h0003);
        repeat (4) @(posedge clk); #1;
        @(negedge clk);
        check("fullpop_cnt0", {16'b0, cnt0}, 32'd6);
        check("fullpop_drained", {31'b0, out0_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation discards both FIFOs
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b0, 16'h0010);
        push(1'b0, 16'h0011);
        push(1'b1, 16'h0020);
        push(1'b1, 16'h0021);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        do_reset(1);
        @(negedge clk);
        check("midrst_out0_valid", {31'b0, out0_valid}, 32'd0);
        check("midrst_out1_valid", {31'b0, out1_valid}, 32'd0);
        check("midrst_cnt0", {16'b0, cnt0}, 32'd0);
        check("midrst_cnt1", {16'b0, cnt1}, 32'd0);
        @(posedge clk); #1;
        push(1'b1, 16'h00FF);
        @(negedge clk);
        check("midrst_first_valid", {31'b0, out1_valid}, 32'd1);
        check("midrst_first_data", {16'b0, out1_data}, 32'h000000FF);
        @(posedge clk); #1;

        // Counter wrap on port 1: 1 + 65535 accepted transfers
        for (int i = 1; i < 65536; i++) begin
            logic [31:0] v;
            v = i;
            push(1'b1, v[15:0] ^ 16'h5A5A);
        end
        repeat (4) @(posedge clk); #1;
        @(negedge clk);
        check("wrap_cnt1", {16'b0, cnt1}, 32'd0);
        check("wrap_cnt0", {16'b0, cnt0}, 32'd0);
        check("wrap_drained", {31'b0, out1_valid}, 32'd0);
        check("end_queue0_empty", exp0.size(), 32'd0);
        check("end_queue1_empty", exp1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_buffered.md
Name: demux_buffered

Overview:
- Sequential counterpart of the datapath 2:1 selector.
- Steers a single valid/ready input stream to one of two destinations under a per-transfer select bit.
- Each destination has its own 2-entry FIFO, so a stalled destination never blocks traffic to the other.
- Used to route processor store/write traffic to either data memory (port 0) or an I/O target (port 1).

Parameters:
- width, 16, data width of input and both outputs.
- cnt_width, 16, width of each per-port transfer counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input transfer request.
- in_sel  input  1  destination: 0 -> port 0, 1 -> port 1.
- in_data  input  width  input payload.
- in_ready  output  1  input accepted this cycle when in_valid && in_ready.
- out0_valid  output  1  port 0 head entry valid.
- out0_data  output  width  port 0 head payload.
- out0_ready  input  1  port 0 consumer accepts.
- out1_valid  output  1  port 1 head entry valid.
- out1_data  output  width  port 1 head payload.
- out1_ready  input  1  port 1 consumer accepts.
- cnt0  output  cnt_width  transfers accepted into port 0 since reset.
- cnt1  output  cnt_width  transfers accepted into port 1 since reset.

Behaviour:
- Reset: one clock with rst=1 sampled high clears everything.
  - Both FIFOs empty; read/write pointers = 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0.
  - in_ready is 1 after reset, because both FIFOs are non-full.
- rst takes priority over every other event. Reset mid-operation discards all buffered entries; any handshake in that cycle is lost and not counted.
- in_ready = in_sel ? ~full1 : ~full0.
  - Combinational on in_sel and FIFO occupancy only; it does not depend on the out*_ready inputs.
  - Consequence: a full FIFO does not accept a push even in a cycle where it pops.
- Upstream holds in_data and in_sel stable while in_valid=1 and in_ready=0.
- Push: on an edge with in_valid && in_ready, the payload is written to FIFO[in_sel], that FIFO's occupancy increments, and cnt[in_sel] increments. The non-selected FIFO is untouched.
- Pop: on an edge with outN_valid && outN_ready, the head is removed from FIFO N.
- Latency: a payload accepted at edge k appears on outN_data with outN_valid=1 after edge k, provided FIFO N was empty. Otherwise it queues behind older entries.
- outN_valid = (occupancyN != 0). outN_data = head entry, registered storage with no combinational bypass from in_data.
- When empty, outN_data holds its last value; consumers ignore it while valid=0.
- Outputs are stable: while outN_valid=1 and outN_ready=0, outN_data does not change.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- Simultaneous push and pop on a FIFO with 1 entry: the old head leaves, the new entry becomes head, and valid stays 1.
- Simultaneous events on different ports are independent.
- Ordering: strict FIFO within each port. No ordering guarantee across ports.
- FIFO pointers: 1-bit index into 2 entries, with occupancy 0..2. Pointers wrap 1 -> 0.
- Counters wrap modulo 2^cnt_width, e.g. 16'hFFFF + 1 -> 16'h0000. They are never saturating.
- in_valid=0: no state change on the input side, regardless of in_sel.

Test Plan:
- Reset then idle: assert rst 2 cycles, release -> out0_valid=out1_valid=0, data=0, cnt0=cnt1=0, in_ready=1.
- Single route: push 16'hA5A5 sel=0 at edge k, out0_ready=1 -> out0_valid=1, out0_data=16'hA5A5 after edge k, popped at k+1. out1_valid stays 0. cnt0=1, cnt1=0.
- Backpressure/isolation:
  - Stimulus: out0_ready=0; push 16'h0001 and 16'h0002 to port 0, then 16'h0003 sel=0, then 16'h0004 sel=1.
  - Response: in_ready=0 while sel=0 after 2 pushes. Changing sel to 1 gives in_ready=1 and port 1 receives 16'h0004.
  - Then raise out0_ready: port 0 delivers 0001, then 0002.
- Full with concurrent pop: port 0 full, out0_ready=1, in_valid=1 sel=0 -> in_ready=0 that cycle. 16'h0003 is accepted the following cycle and delivered after 0002.
- Wrap: drive 65536 accepted transfers to port 1 with out1_ready=1 -> cnt1 returns to 0, and all data is delivered in order.
- Reset mid-operation: both FIFOs holding 2 entries, assert rst for 1 cycle -> both valids 0, counters 0. A subsequent push of 16'h00FF to port 1 is the first data seen on out1_data.
